// File: rtl/alarm_pio_pkg.sv
// Shared definitions for the alarm PIO family (key input and display outputs):
// Avalon word addresses and edge-capture mode encodings.
package alarm_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD     = 2'd2;
  localparam logic [1:0] ADDR_EDGE     = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // One bit of edge detection between the current and previous stable level
  function automatic logic edge_bit(input int edge_type, input logic cur, input logic prev);
    case (edge_type)
      EDGE_RISING:  edge_bit = cur & ~prev;
      EDGE_FALLING: edge_bit = ~cur & prev;
      default:      edge_bit = cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/alarm_key_debounce.sv
// One key bit: 2-flop synchronizer followed by the stable-level register.
// With ALARM_KEY_DEBOUNCE_EN defined, the stable level only follows the
// synchronized input after DEBOUNCE_CYCLES consecutive differing cycles.
module alarm_key_debounce #(
  parameter int IDLE_LEVEL      = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic stable
);

  localparam logic IDLE = (IDLE_LEVEL != 0);

  logic sync1_q, sync1_d;
  logic sync_q, sync_d;
  logic stable_q, stable_d;

  // Synchronizer chain
  always_comb begin
    sync1_d = in_raw;
    sync_d  = sync1_q;
  end

`ifdef ALARM_KEY_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (DEBOUNCE_CYCLES < 1) ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; accept the new level on the last one
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Debounce counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Without debounce the stable level is the synchronized input one cycle later
  always_comb stable_d = sync_q;
`endif

  // Synchronizer and stable-level registers, idle level out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= IDLE;
      sync_q   <= IDLE;
      stable_q <= IDLE;
    end else begin
      sync1_q  <= sync1_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/alarm_key_pio.sv
// Avalon-MM key input PIO: per-bit synchronizer/debounce, sticky edge capture
// with write-1-to-clear, interrupt mask and a registered level irq.
// Optional debounce is enabled by defining ALARM_KEY_DEBOUNCE_EN.
module alarm_key_pio
  import alarm_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{(IDLE_LEVEL != 0)}};

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic             unused_wdata;

  // Upper write-data bits carry no register state
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    alarm_key_debounce #(
      .IDLE_LEVEL      (IDLE_LEVEL),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
      .clk     (clk),
      .reset_n (reset_n),
      .in_raw  (in_port[i]),
      .stable  (stable[i])
    );
  end

  // Edge detect against the previous stable level
  always_comb begin
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++) edge_det[i] = edge_bit(EDGE_TYPE, stable[i], prev_q[i]);
  end

  // Register-file next state; a new edge beats a same-cycle clear
  always_comb begin
    wr_en  = chipselect & ~write_n;
    prev_d = stable;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && address == ADDR_IRQ_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE)     clr    = writedata[WIDTH-1:0];
    edge_d = (edge_q & ~clr) | edge_det;
    irq_d  = |(edge_q & mask_q);
  end

  // Register file, previous level and irq registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= IDLE_VEC;
      mask_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      irq_q  <= irq_d;
    end
  end

  // Zero-latency read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(stable);
      ADDR_IRQ_MASK: readdata = 32'(mask_q);
      ADDR_EDGE:     readdata = 32'(edge_q);
      default:       readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_alarm_key_pio.sv
// Bench for alarm_key_pio: a history-based model of the key path and register
// map checked every cycle, plus directed literal checks. A second instance
// with any-edge capture covers that mode.
module tb_alarm_key_pio;

  localparam int DC = 4;
`ifdef ALARM_KEY_DEBOUNCE_EN
  localparam int LAT = 3 + DC;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs = 1'b0, cs2 = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF, in2 = 4'hF;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alarm_key_pio #(.WIDTH(4), .EDGE_TYPE(1), .IDLE_LEVEL(1), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq));

  alarm_key_pio #(.WIDTH(4), .EDGE_TYPE(2), .IDLE_LEVEL(1), .DEBOUNCE_CYCLES(DC)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(readdata2), .irq(irq2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model (first instance, falling-edge capture) ----------------
  // smp[k]: in_port seen at the k-th clock edge after reset; lvl[k]: stable level after edge k.
  logic [3:0] smp [0:8191];
  logic [3:0] lvl [0:8191];
  int         n = 0;
  logic [3:0] m_mask = '0, m_cap = '0;
  logic       m_irq = 1'b0;

  function automatic logic [3:0] smp_at(input int i);
    return (i < 1) ? 4'hF : smp[i];
  endfunction
  function automatic logic [3:0] lvl_at(input int i);
    return (i < 1) ? 4'hF : lvl[i];
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      n = 0; m_mask = '0; m_cap = '0; m_irq = 1'b0;
    end else begin
      logic [3:0] nl, s, ev, clr;
      logic       flip;
      n++;
      smp[n] = in_port;
      nl = lvl_at(n - 1);
`ifdef ALARM_KEY_DEBOUNCE_EN
      // A bit flips once the synchronized value has disagreed for DC cycles in a row
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int j = 0; j < DC; j++) begin
          s = smp_at(n - 2 - j);
          if (s[b] == nl[b]) flip = 1'b0;
        end
        if (flip) nl[b] = ~nl[b];
      end
`else
      flip = 1'b0;
      s    = '0;
      nl   = smp_at(n - 2);
`endif
      lvl[n] = nl;
      ev  = lvl_at(n - 2) & ~lvl_at(n - 1);
      clr = (cs && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      m_irq = |(m_cap & m_mask);
      m_cap = (m_cap & ~clr) | ev;
      if (cs && !write_n && address == 2'd1) m_mask = writedata[3:0];
    end
  end

  // Every-cycle compare against the model
  initial forever begin
    logic [31:0] exp_rd;
    @(negedge clk);
    case (address)
      2'd0:    exp_rd = {28'b0, lvl_at(n)};
      2'd1:    exp_rd = {28'b0, m_mask};
      2'd3:    exp_rd = {28'b0, m_cap};
      default: exp_rd = '0;
    endcase
    chk("model_readdata", readdata, exp_rd);
    chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
  end

  // ---------------- directed stimulus ----------------
  task automatic rd(input int which, input logic [1:0] a, input logic [31:0] exp, input string name);
    #1 address = a;
    #1 chk(name, (which != 0) ? readdata2 : readdata, exp);
  endtask

  task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #2 address = a; writedata = d; write_n = 1'b0;
    if (which != 0) cs2 = 1'b1; else cs = 1'b1;
    @(posedge clk);
    #2 cs = 1'b0; cs2 = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd(0, 2'd0, 32'hF, "rst_data");
    rd(0, 2'd1, 32'h0, "rst_mask");
    chk("rst_irq", {31'b0, irq}, 32'h0);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rd(0, 2'd3, 32'h0, "no_spurious_cap");
    rd(1, 2'd3, 32'h0, "no_spurious_cap2");

    // Falling edge on bit2 with mask set
    wr(0, 2'd1, 32'h4);
    @(negedge clk); rd(0, 2'd1, 32'h4, "mask_wr");
    @(posedge clk); #2 in_port = 4'hB;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk); rd(0, 2'd3, 32'h0, "cap_early");
    @(negedge clk); rd(0, 2'd3, 32'h4, "cap_latency");
    chk("irq_before", {31'b0, irq}, 32'h0);
    rd(0, 2'd0, 32'hB, "data_b");
    @(negedge clk); chk("irq_latency", {31'b0, irq}, 32'h1);

    // Write-1-to-clear
    wr(0, 2'd3, 32'h4);
    @(negedge clk); rd(0, 2'd3, 32'h0, "clr_cap");
    chk("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk); chk("irq_clr", {31'b0, irq}, 32'h0);

    // Capture while masked, then unmask
    wr(0, 2'd1, 32'h0);
    @(posedge clk); #2 in_port = 4'h9;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk); rd(0, 2'd3, 32'h2, "cap_masked");
    chk("irq_masked", {31'b0, irq}, 32'h0);
    wr(0, 2'd1, 32'h2);
    @(negedge clk); chk("unmask_lag", {31'b0, irq}, 32'h0);
    @(negedge clk); chk("unmask_irq", {31'b0, irq}, 32'h1);

    // Release (rising, not captured), then clear and new edge in the same cycle
    @(posedge clk); #2 in_port = 4'hB;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk); rd(0, 2'd3, 32'h2, "rise_ignored");
    @(posedge clk); #2 in_port = 4'h9;
    repeat (LAT - 2) @(posedge clk);
    wr(0, 2'd3, 32'h2);
    @(negedge clk); rd(0, 2'd3, 32'h2, "set_wins");
    chk("set_wins_irq", {31'b0, irq}, 32'h1);
    @(negedge clk); chk("irq_stays", {31'b0, irq}, 32'h1);

    // Read-only and reserved words
    wr(0, 2'd0, 32'h0);
    @(negedge clk); rd(0, 2'd0, 32'h9, "data_ro");
    wr(0, 2'd2, 32'hFFFF_FFFF);
    @(negedge clk); rd(0, 2'd2, 32'h0, "rsvd_zero");

    // Any-edge instance: press and release bit3
    @(posedge clk); #2 in2 = 4'h7;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk); rd(1, 2'd3, 32'h8, "any_press");
    wr(1, 2'd3, 32'h8);
    @(negedge clk); rd(1, 2'd3, 32'h0, "any_clr");
    @(posedge clk); #2 in2 = 4'hF;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk); rd(1, 2'd3, 32'h8, "any_release");
    chk("any_irq_masked", {31'b0, irq2}, 32'h0);

`ifdef ALARM_KEY_DEBOUNCE_EN
    // Short glitch rejected, long pulse accepted
    @(posedge clk); #2 in_port = 4'h8;
    repeat (3) @(posedge clk); #2 in_port = 4'h9;
    repeat (10) @(posedge clk);
    @(negedge clk); rd(0, 2'd0, 32'h9, "glitch_data");
    rd(0, 2'd3, 32'h2, "glitch_cap");
    @(posedge clk); #2 in_port = 4'h8;
    repeat (6) @(posedge clk);
    @(negedge clk); rd(0, 2'd0, 32'h8, "db_data");
    #1 in_port = 4'h9;
    repeat (12) @(posedge clk);
    @(negedge clk); rd(0, 2'd3, 32'h3, "db_cap");
`endif

    // Asynchronous reset mid-debounce / mid-capture
    @(posedge clk); #2 in_port = 4'h1;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("rst_async_irq", {31'b0, irq}, 32'h0);
    rd(0, 2'd1, 32'h0, "rst_async_mask");
    rd(0, 2'd3, 32'h0, "rst_async_cap");
    rd(0, 2'd0, 32'hF, "rst_async_data");
    in_port = 4'hF;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk); rd(0, 2'd3, 32'h0, "post_rst_cap");
    rd(0, 2'd0, 32'hF, "post_rst_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
